// File: rtl/fft_result_reader_pkg.sv
// Shared definitions for the FFT result read-back path: buffer states, CTRL bit positions
// and the STATUS word layout seen by the core.
package fft_result_reader_pkg;

    typedef enum logic {
        FFT_RD_EMPTY = 1'b0,
        FFT_RD_FULL  = 1'b1
    } fft_rd_state_t;

    localparam int unsigned FFT_CTRL_RELEASE = 0;
    localparam int unsigned FFT_CTRL_CLR_OVF = 1;

    localparam int unsigned FFT_STAT_FULL = 0;
    localparam int unsigned FFT_STAT_OVF  = 1;
    localparam int unsigned FFT_STAT_IRQ  = 2;
    localparam int unsigned FFT_STAT_CNT  = 16;
    localparam int unsigned FFT_CNT_W     = 16;

    function automatic logic [31:0] fft_status_word(
        input logic [FFT_CNT_W-1:0] cnt,
        input logic                 ovf,
        input logic                 full
    );
        logic [31:0] w;
        w = '0;
        w[FFT_STAT_CNT +: FFT_CNT_W] = cnt;
        w[FFT_STAT_IRQ]              = 1'b0;  // interrupt is a pulse, never left pending
        w[FFT_STAT_OVF]              = ovf;
        w[FFT_STAT_FULL]             = full;
        return w;
    endfunction

endpackage

// File: rtl/fft_result_reader.sv
// Single-frame result buffer for the FFT accelerator: parallel capture of real/imag words,
// word-wise bus read-back, STATUS/CTRL register, frame counter, overflow flag and capture irq.
module fft_result_reader
    import fft_result_reader_pkg::*;
#(
    parameter int unsigned MEMWIDTH     = 64,
    parameter int unsigned WORDWIDTH    = 16,
    parameter bit          AUTO_RELEASE = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en_i,
    input  logic                                  we_i,
    input  logic [31:0]                           addr_i,
    input  logic [31:0]                           data_i,
    output logic [31:0]                           data_o,
    input  logic                                  fft_valid_i,
    input  logic [MEMWIDTH/2-1:0][WORDWIDTH-1:0]  fft_data_r_i,
    input  logic [MEMWIDTH/2-1:0][WORDWIDTH-1:0]  fft_data_i_i,
    output logic                                  fft_ready_o,
    output logic                                  irq_o
);

    localparam int unsigned NPOINTS = MEMWIDTH / 2;
    localparam int unsigned AW      = $clog2(MEMWIDTH);

    fft_rd_state_t          r_state;
    logic [WORDWIDTH-1:0]   r_mem [MEMWIDTH];
    logic [FFT_CNT_W-1:0]   r_cnt;
    logic                   r_ovf;
    logic                   r_irq;
    logic [31:0]            r_data;

    logic                   w_rd;
    logic                   w_is_data;
    logic                   w_is_ctrl;
    logic                   w_wr_ctrl;
    logic                   w_capture;
    logic                   w_overflow;
    logic                   w_release;
    logic                   w_clr_ovf;
    logic [AW-1:0]          w_idx;
    logic [31:0]            w_rd_data;
    logic                   w_unused;

    assign fft_ready_o = (r_state == FFT_RD_EMPTY);
    assign irq_o       = r_irq;
    assign data_o      = r_data;

    assign w_rd       = en_i && !we_i;
    assign w_is_data  = (addr_i < 32'(MEMWIDTH));
    assign w_is_ctrl  = (addr_i == 32'(MEMWIDTH));
    assign w_wr_ctrl  = en_i && we_i && w_is_ctrl;
    assign w_idx      = addr_i[AW-1:0];
    assign w_unused   = ^data_i;

    assign w_capture  = fft_valid_i && fft_ready_o;
    assign w_overflow = fft_valid_i && !fft_ready_o;
    assign w_clr_ovf  = w_wr_ctrl && data_i[FFT_CTRL_CLR_OVF];

    // Auto-release keys off the read of the final imag word; the read data itself is
    // sampled from the still-valid buffer on the same edge.
    assign w_release  = (w_wr_ctrl && data_i[FFT_CTRL_RELEASE]) ||
                        (AUTO_RELEASE && w_rd && (addr_i == 32'(MEMWIDTH - 1)) &&
                         (r_state == FFT_RD_FULL));

    always_comb begin
        w_rd_data = '0;
        if (w_is_data) begin
            w_rd_data = 32'($signed(r_mem[w_idx]));
        end else if (w_is_ctrl) begin
            w_rd_data = fft_status_word(r_cnt, r_ovf, r_state == FFT_RD_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FFT_RD_EMPTY;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_irq   <= 1'b0;
            r_data  <= '0;
            for (int unsigned k = 0; k < MEMWIDTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            r_irq <= w_capture;

            if (w_rd) begin
                r_data <= w_rd_data;
            end

            if (w_capture) begin
                for (int unsigned k = 0; k < NPOINTS; k++) begin
                    r_mem[k]           <= fft_data_r_i[k];
                    r_mem[k + NPOINTS] <= fft_data_i_i[k];
                end
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                FFT_RD_EMPTY: if (fft_valid_i) r_state <= FFT_RD_FULL;
                FFT_RD_FULL:  if (w_release)   r_state <= FFT_RD_EMPTY;
                default:                       r_state <= FFT_RD_EMPTY;
            endcase

            // A dropped frame in the same cycle as a clear request keeps the flag set.
            if (w_overflow) begin
                r_ovf <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader: a manual-release instance and an auto-release instance.
module tb_fft_result_reader;

    localparam int unsigned MW = 64;
    localparam int unsigned NP = MW / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  en, we, valid;
    logic [31:0]           addr, wdata, rdata;
    logic                  ready, irq;
    logic                  a_en, a_we, a_valid;
    logic [31:0]           a_addr, a_wdata, a_rdata;
    logic                  a_ready, a_irq;
    logic [NP-1:0][15:0]   fr, fi;

    int total = 0;
    int bad   = 0;
    int exp_cnt;
    logic [31:0] d;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t tbl [10];

    fft_result_reader #(.MEMWIDTH(MW), .WORDWIDTH(16), .AUTO_RELEASE(1'b0)) u_dut (
        .clk(clk), .rst(rst), .en_i(en), .we_i(we), .addr_i(addr), .data_i(wdata),
        .data_o(rdata), .fft_valid_i(valid), .fft_data_r_i(fr), .fft_data_i_i(fi),
        .fft_ready_o(ready), .irq_o(irq)
    );

    fft_result_reader #(.MEMWIDTH(MW), .WORDWIDTH(16), .AUTO_RELEASE(1'b1)) u_auto (
        .clk(clk), .rst(rst), .en_i(a_en), .we_i(a_we), .addr_i(a_addr), .data_i(a_wdata),
        .data_o(a_rdata), .fft_valid_i(a_valid), .fft_data_r_i(fr), .fft_data_i_i(fi),
        .fft_ready_o(a_ready), .irq_o(a_irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] q);
        en = 1'b1; we = 1'b0; addr = a;
        tick();
        en = 1'b0;
        q = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        en = 1'b1; we = 1'b1; addr = a; wdata = v;
        tick();
        en = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic pulse();
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic a_rd(input logic [31:0] a, output logic [31:0] q);
        a_en = 1'b1; a_we = 1'b0; a_addr = a;
        tick();
        a_en = 1'b0;
        q = a_rdata;
    endtask

    task automatic a_pulse();
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'd0,          32'h0000_0000};
        tbl[1] = '{32'd5,          32'h0000_0005};
        tbl[2] = '{32'd31,         32'h0000_001F};
        tbl[3] = '{32'd32,         32'h0000_0000};
        tbl[4] = '{32'd37,         32'hFFFF_FFFB};
        tbl[5] = '{32'd63,         32'hFFFF_FFE1};
        tbl[6] = '{32'd64,         32'h0001_0001};
        tbl[7] = '{32'd65,         32'h0000_0000};
        tbl[8] = '{32'd1000,       32'h0000_0000};
        tbl[9] = '{32'hFFFF_FFFF,  32'h0000_0000};

        rst = 1'b0;
        en = 1'b0; we = 1'b0; valid = 1'b0; addr = '0; wdata = '0;
        a_en = 1'b0; a_we = 1'b0; a_valid = 1'b0; a_addr = '0; a_wdata = '0;
        fr = '0; fi = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_o", rdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_ready", {31'b0, ready}, 32'h1);
        rst = 1'b1;
        tick();
        rd(32'd64, d); chk("reset_status", d, 32'h0000_0000);

        // frame 1: real[k]=k, imag[k]=-k
        for (int k = 0; k < NP; k++) begin
            fr[k] = 16'(k);
            fi[k] = 16'(-k);
        end
        chk("pre_capture_irq", {31'b0, irq}, 32'h0);
        pulse();
        chk("capture_irq", {31'b0, irq}, 32'h1);
        chk("capture_ready", {31'b0, ready}, 32'h0);
        tick();
        chk("irq_one_cycle", {31'b0, irq}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            rd(tbl[i].addr, d);
            chk($sformatf("rd_addr_%0h", tbl[i].addr), d, tbl[i].exp);
        end
        chk("no_auto_release", {31'b0, ready}, 32'h0);

        rd(32'd37, d);
        repeat (3) tick();
        chk("data_o_hold", rdata, 32'hFFFF_FFFB);

        // overflow while FULL: buffer untouched
        for (int k = 0; k < NP; k++) begin
            fr[k] = 16'h7FFF;
            fi[k] = 16'h7FFF;
        end
        pulse();
        chk("ovf_ready", {31'b0, ready}, 32'h0);
        chk("ovf_no_irq", {31'b0, irq}, 32'h0);
        rd(32'd5, d);  chk("ovf_buf_real", d, 32'h0000_0005);
        rd(32'd40, d); chk("ovf_buf_imag", d, 32'hFFFF_FFF8);
        rd(32'd64, d); chk("ovf_status", d, 32'h0001_0003);
        wr(32'd64, 32'h2);
        rd(32'd64, d); chk("ovf_cleared", d, 32'h0001_0001);

        // release and valid together: frame dropped, overflow flagged
        en = 1'b1; we = 1'b1; addr = 32'd64; wdata = 32'h1; valid = 1'b1;
        tick();
        en = 1'b0; we = 1'b0; wdata = '0; valid = 1'b0;
        chk("race_ready", {31'b0, ready}, 32'h1);
        chk("race_no_irq", {31'b0, irq}, 32'h0);
        rd(32'd64, d); chk("race_status", d, 32'h0001_0002);
        wr(32'd64, 32'h2);
        rd(32'd64, d); chk("race_clr", d, 32'h0001_0000);
        rd(32'd5, d);  chk("empty_read_old", d, 32'h0000_0005);

        // frame 2
        for (int k = 0; k < NP; k++) begin
            fr[k] = 16'h8000 + 16'(k);
            fi[k] = 16'h0100 + 16'(k);
        end
        pulse();
        chk("cap2_irq", {31'b0, irq}, 32'h1);
        rd(32'd2, d);  chk("cap2_real_neg", d, 32'hFFFF_8002);
        rd(32'd33, d); chk("cap2_imag", d, 32'h0000_0101);

        wr(32'd3, 32'h3);
        chk("write_keeps_data_o", rdata, 32'h0000_0101);
        wr(32'd65, 32'h3);
        wr(32'd0, 32'h1);
        rd(32'd64, d); chk("ign_write_status", d, 32'h0002_0001);
        rd(32'd3, d);  chk("ign_write_data", d, 32'hFFFF_8003);

        // overflow beats a same-cycle clear
        en = 1'b1; we = 1'b1; addr = 32'd64; wdata = 32'h2; valid = 1'b1;
        tick();
        en = 1'b0; we = 1'b0; wdata = '0; valid = 1'b0;
        rd(32'd64, d); chk("ovf_wins", d, 32'h0002_0003);
        wr(32'd64, 32'h3);
        rd(32'd64, d); chk("rel_clr_status", d, 32'h0002_0000);
        rd(32'd63, d); chk("empty_last_imag", d, 32'h0000_011F);

        exp_cnt = 2;
        for (int i = 0; i < 10; i++) begin
            fr[0] = 16'(i);
            pulse();
            exp_cnt++;
            wr(32'd64, 32'h1);
        end
        rd(32'd64, d); chk("cnt_status", d, {16'(exp_cnt), 16'h0000});
        rd(32'd0, d);  chk("cnt_last_frame", d, 32'h0000_0009);

        // auto-release instance
        for (int k = 0; k < NP; k++) begin
            fr[k] = 16'(k);
            fi[k] = 16'(-k);
        end
        a_pulse();
        chk("auto_irq", {31'b0, a_irq}, 32'h1);
        chk("auto_full", {31'b0, a_ready}, 32'h0);
        a_rd(32'd62, d); chk("auto_rd62", d, 32'hFFFF_FFE2);
        chk("auto_still_full", {31'b0, a_ready}, 32'h0);
        a_rd(32'd63, d); chk("auto_rd63", d, 32'hFFFF_FFE1);
        chk("auto_released", {31'b0, a_ready}, 32'h1);
        a_rd(32'd64, d); chk("auto_status", d, 32'h0001_0000);
        for (int k = 0; k < NP; k++) fr[k] = 16'(k + 16);
        a_pulse();
        chk("auto_recap_full", {31'b0, a_ready}, 32'h0);
        a_rd(32'd1, d);  chk("auto_recap_data", d, 32'h0000_0011);
        a_rd(32'd64, d); chk("auto_recap_status", d, 32'h0002_0001);

        // asynchronous reset while FULL with irq high and a read in flight
        pulse();
        en = 1'b1; we = 1'b0; addr = 32'd5;
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_data_o", rdata, 32'h0);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        chk("mid_rst_ready", {31'b0, ready}, 32'h1);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        rd(32'd64, d); chk("mid_rst_status", d, 32'h0000_0000);
        rd(32'd5, d);  chk("mid_rst_buf", d, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
